// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder controller.
package serial_add_pkg;
  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;
endpackage

// File: rtl/fa_cell.sv
// Single-bit combinational full adder used once per serial step.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: LSB-first, one bit per clock, result held in DONE
// until taken.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d, sum_q, sum_d;
  logic             carry_q, carry_d, c_out_q, c_out_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             fa_s, fa_co;

  fa_cell u_fa (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_co)
  );

  // Partial sum lives in acc_q so the visible sum only changes on completion.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    c_out_d = c_out_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = c_in;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d   = {fa_s, acc_q[WIDTH-1:1]};
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = fa_co;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          sum_d   = {fa_s, acc_q[WIDTH-1:1]};
          c_out_d = fa_co;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      c_out_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      c_out_q <= c_out_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == RUN);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign c_out     = c_out_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed and randomized checks of serial_add_ctrl against a plain-arithmetic model.
module tb_serial_add_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic         c_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         c_out;
  logic         busy;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] prev_sum;
  logic         prev_cout;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full transaction: accept, run (optionally with noisy inputs), hold in DONE, release.
  task automatic do_add(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                        input int hold, input bit noisy);
    logic [W:0] exp_full;
    int n;
    exp_full = {1'b0, ta} + {1'b0, tb_} + {{W{1'b0}}, tc};
    a = ta; b = tb_; c_in = tc; in_valid = 1'b1; out_ready = 1'b0;
    chk("idle_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    chk("run_busy", busy, 1);
    chk("run_not_ready", in_ready, 0);
    n = 0;
    while (!out_valid && n < 4 * W) begin
      chk("run_sum_held", sum, prev_sum);
      if (noisy) begin
        a = W'($urandom); b = W'($urandom); c_in = 1'($urandom);
        in_valid = 1'($urandom);
      end
      step();
      n++;
    end
    in_valid = 1'b0;
    chk("latency", n, W);
    chk("sum", sum, exp_full[W-1:0]);
    chk("c_out", c_out, exp_full[W]);
    for (int i = 0; i < hold; i++) begin
      a = W'($urandom); b = W'($urandom);
      step();
      chk("bp_valid", out_valid, 1);
      chk("bp_ready", in_ready, 0);
      chk("bp_sum", sum, exp_full[W-1:0]);
      chk("bp_cout", c_out, exp_full[W]);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("back_idle", in_ready, 1);
    chk("back_not_valid", out_valid, 0);
    prev_sum  = exp_full[W-1:0];
    prev_cout = exp_full[W];
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_sum"}, sum, 0);
    chk({tag, "_c_out"}, c_out, 0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; c_in = 1'b0; out_ready = 1'b0;
    prev_sum = '0; prev_cout = 1'b0;
    step(); step();
    rst = 1'b0;
    chk_reset_state("reset");

    do_add(8'h0F, 8'h01, 1'b0, 0, 1'b0);
    do_add(8'hFF, 8'h01, 1'b0, 1, 1'b0);
    do_add(8'hFF, 8'hFF, 1'b1, 5, 1'b0);
    do_add(8'h00, 8'h00, 1'b1, 0, 1'b0);

    // Reset three cycles into a run discards the partial result.
    a = 8'hAA; b = 8'h55; c_in = 1'b1; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_reset_state("midrun_rst");
    prev_sum = '0; prev_cout = 1'b0;
    do_add(8'h12, 8'h34, 1'b0, 0, 1'b0);

    // Reset wins over a same-edge in_valid.
    rst = 1'b1; in_valid = 1'b1; a = 8'h77; b = 8'h11;
    step();
    rst = 1'b0; in_valid = 1'b0;
    chk_reset_state("rst_prio");
    prev_sum = '0; prev_cout = 1'b0;

    for (int k = 0; k < 12; k++)
      do_add(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)), 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
